// File: rtl/data_mem_sync.sv
// Synchronous 32-bit data memory with byte/half/word access, alignment checking
// and an optional zero-fill sequence after reset.
module data_mem_sync #(
   parameter int ADDR_W         = 12,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic [31:0]       rdata,
   output logic              rvalid,
   output logic              misalign
);

   localparam int IDX_W = ADDR_W - 2;
   localparam int DEPTH = 1 << IDX_W;

   typedef enum logic {INIT, IDLE} state_t;

   state_t           state;
   logic [IDX_W-1:0] cnt;
   logic [31:0]      mem [DEPTH];

   logic [IDX_W-1:0] idx_p0;
   logic [1:0]       off_p0;
   logic             legal_p0;
   logic [3:0]       mask_p0;
   logic [31:0]      wsh_p0;
   logic             wr_p0;

   function automatic logic is_legal(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         2'b00:   is_legal = 1'b1;
         2'b01:   is_legal = ~off[0];
         2'b10:   is_legal = (off == 2'b00);
         default: is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         2'b00:   lane_mask = 4'b0001 << off;
         2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
         default: lane_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] off, input logic sx);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (sz)
         2'b00:   load_extend = sx ? {{24{sh[7]}}, sh[7:0]}   : {24'h0, sh[7:0]};
         2'b01:   load_extend = sx ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
         default: load_extend = word;
      endcase
   endfunction

   assign ready    = (state == IDLE) && !reset;
   assign idx_p0   = addr[ADDR_W-1:2];
   assign off_p0   = addr[1:0];
   assign legal_p0 = is_legal(size, off_p0);
   assign mask_p0  = lane_mask(size, off_p0);
   assign wsh_p0   = wdata << {off_p0, 3'b000};
   assign wr_p0    = ready && en && we && legal_p0;

   // Array: zero-fill while in INIT, otherwise lane-masked stores.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[cnt] <= '0;
      end else if (wr_p0) begin
         for (int k = 0; k < 4; k++) begin
            if (mask_p0[k]) mem[idx_p0][8*k +: 8] <= wsh_p0[8*k +: 8];
         end
      end
   end

   // Control and registered load result, one cycle after acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= CLEAR_ON_RESET ? INIT : IDLE;
         cnt      <= '0;
         rdata    <= '0;
         rvalid   <= 1'b0;
         misalign <= 1'b0;
      end else begin
         rvalid   <= 1'b0;
         misalign <= 1'b0;
         case (state)
            INIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == '1) state <= IDLE;
            end
            default: begin
               if (en) begin
                  if (!legal_p0) begin
                     misalign <= 1'b1;
                  end else if (!we) begin
                     rvalid <= 1'b1;
                     rdata  <= load_extend(mem[idx_p0], size, off_p0, sign_ext);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_sync.sv
// Directed bench for data_mem_sync with ADDR_W=6 (16 words): reset/clear timing,
// lane mapping, extension, alignment errors, read-after-write and reset mid-traffic.
module tb_data_mem_sync;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [5:0]  addr;
   logic [31:0] wdata;
   logic        ready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        misalign;

   int checks = 0;
   int errors = 0;

   data_mem_sync #(.ADDR_W(6), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .reset(reset), .en(en), .we(we), .size(size), .sign_ext(sign_ext),
      .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .rvalid(rvalid),
      .misalign(misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   // Present one request for one edge; outputs are sampled 1 time unit after that edge.
   task automatic drive(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [5:0] a, input logic [31:0] d);
      en = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
      @(posedge clk); #1;
      en = 1'b0;
   endtask

   task automatic idle();
      en = 1'b0;
      @(posedge clk); #1;
   endtask

   // Release reset and require exactly 16 cycles of ready=0 followed by ready=1.
   task automatic release_and_wait_clear(input string name);
      int low_cnt;
      reset = 1'b0;
      low_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (ready === 1'b0) low_cnt++;
         @(posedge clk); #1;
      end
      checks++;
      if (low_cnt != 16) begin
         errors++;
         $display("FAIL %s ready_low_cycles: got %0d required 16", name, low_cnt);
      end
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_after_clear: got %b required 1", name, ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b0; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = '0; wdata = '0;
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if ({ready, rvalid, misalign} !== 3'b000 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: got ready=%b rvalid=%b misalign=%b rdata=%h required 0/0/0/00000000",
                  ready, rvalid, misalign, rdata);
      end
      release_and_wait_clear("reset");
   endtask

   // Back-to-back word loads across the whole array, one per cycle.
   task automatic test_read_all_zero(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 2'b10, 1'b0, 6'(i * 4), 32'h0);
         if (rvalid !== 1'b1 || rdata !== 32'h0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s lw_all_zero: got %0d bad words required 0", name, bad);
      end
   endtask

   task automatic test_sign_ext();
      drive(1'b1, 2'b10, 1'b0, 6'h10, 32'h800000F1);
      checks++;
      if (rvalid !== 1'b0) begin
         errors++;
         $display("FAIL sw_rvalid: got %b required 0", rvalid);
      end
      drive(1'b0, 2'b00, 1'b1, 6'h10, 32'h0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'hFFFFFFF1) begin
         errors++;
         $display("FAIL lb_0x10: got %b/%h required 1/FFFFFFF1", rvalid, rdata);
      end
      drive(1'b0, 2'b00, 1'b0, 6'h13, 32'h0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h00000080) begin
         errors++;
         $display("FAIL lbu_0x13: got %b/%h required 1/00000080", rvalid, rdata);
      end
      drive(1'b0, 2'b01, 1'b1, 6'h12, 32'h0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'hFFFF8000) begin
         errors++;
         $display("FAIL lh_0x12: got %b/%h required 1/FFFF8000", rvalid, rdata);
      end
      drive(1'b0, 2'b01, 1'b0, 6'h12, 32'h0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h00008000) begin
         errors++;
         $display("FAIL lhu_0x12: got %b/%h required 1/00008000", rvalid, rdata);
      end
      drive(1'b0, 2'b10, 1'b1, 6'h10, 32'h0);
      checks++;
      if (rdata !== 32'h800000F1) begin
         errors++;
         $display("FAIL lw_sx_ignored: got %h required 800000F1", rdata);
      end
   endtask

   task automatic test_lanes();
      drive(1'b1, 2'b10, 1'b0, 6'h20, 32'h11223344);
      drive(1'b1, 2'b00, 1'b0, 6'h21, 32'h000000AB);
      drive(1'b1, 2'b01, 1'b0, 6'h22, 32'h0000BEEF);
      drive(1'b0, 2'b10, 1'b0, 6'h20, 32'h0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'hBEEFAB44) begin
         errors++;
         $display("FAIL lanes_lw_0x20: got %b/%h required 1/BEEFAB44", rvalid, rdata);
      end
      drive(1'b0, 2'b00, 1'b1, 6'h21, 32'h0);
      checks++;
      if (rdata !== 32'hFFFFFFAB) begin
         errors++;
         $display("FAIL lanes_lb_0x21: got %h required FFFFFFAB", rdata);
      end
   endtask

   task automatic test_misalign();
      drive(1'b1, 2'b10, 1'b0, 6'h04, 32'h01020304);
      drive(1'b0, 2'b10, 1'b0, 6'h04, 32'h0);
      checks++;
      if (rdata !== 32'h01020304 || misalign !== 1'b0) begin
         errors++;
         $display("FAIL mis_setup: got %h/%b required 01020304/0", rdata, misalign);
      end
      drive(1'b0, 2'b10, 1'b0, 6'h06, 32'h0);
      checks++;
      if (misalign !== 1'b1 || rvalid !== 1'b0 || rdata !== 32'h01020304) begin
         errors++;
         $display("FAIL mis_lw_0x06: got m=%b v=%b d=%h required 1/0/01020304", misalign, rvalid, rdata);
      end
      idle();
      checks++;
      if (misalign !== 1'b0 || rvalid !== 1'b0) begin
         errors++;
         $display("FAIL mis_pulse_width: got m=%b v=%b required 0/0", misalign, rvalid);
      end
      drive(1'b0, 2'b01, 1'b1, 6'h05, 32'h0);
      checks++;
      if (misalign !== 1'b1 || rvalid !== 1'b0) begin
         errors++;
         $display("FAIL mis_lh_0x05: got m=%b v=%b required 1/0", misalign, rvalid);
      end
      drive(1'b0, 2'b11, 1'b0, 6'h08, 32'h0);
      checks++;
      if (misalign !== 1'b1 || rvalid !== 1'b0) begin
         errors++;
         $display("FAIL mis_size11: got m=%b v=%b required 1/0", misalign, rvalid);
      end
      drive(1'b1, 2'b01, 1'b0, 6'h05, 32'h0000FFFF);
      checks++;
      if (misalign !== 1'b1 || rvalid !== 1'b0) begin
         errors++;
         $display("FAIL mis_sh_0x05: got m=%b v=%b required 1/0", misalign, rvalid);
      end
      drive(1'b1, 2'b11, 1'b0, 6'h04, 32'hFFFFFFFF);
      drive(1'b0, 2'b10, 1'b0, 6'h04, 32'h0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h01020304 || misalign !== 1'b0) begin
         errors++;
         $display("FAIL mis_word_kept: got v=%b d=%h m=%b required 1/01020304/0", rvalid, rdata, misalign);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 2'b10, 1'b0, 6'h04, 32'hCAFEF00D);
      drive(1'b0, 2'b10, 1'b0, 6'h04, 32'h0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL raw_lw_0x04: got %b/%h required 1/CAFEF00D", rvalid, rdata);
      end
      idle();
      checks++;
      if (rvalid !== 1'b0 || rdata !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL raw_hold: got %b/%h required 0/CAFEF00D", rvalid, rdata);
      end
   endtask

   task automatic test_reset_in_init();
      int spurious;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      spurious = 0;
      // Requests during INIT (after index 0 is cleared) must be ignored.
      for (int i = 0; i < 8; i++) begin
         if (i >= 2) begin
            drive(1'b1, 2'b10, 1'b0, 6'h00, 32'hFFFFFFFF);
         end else begin
            drive(1'b0, 2'b10, 1'b0, 6'h06, 32'h0);
         end
         if (rvalid !== 1'b0 || misalign !== 1'b0) spurious++;
      end
      checks++;
      if (spurious != 0) begin
         errors++;
         $display("FAIL init_ignored: got %0d spurious responses required 0", spurious);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      release_and_wait_clear("init_reset");
      test_read_all_zero("init_reset");
   endtask

   task automatic test_reset_during_lw();
      drive(1'b1, 2'b10, 1'b0, 6'h08, 32'h12345678);
      drive(1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
      checks++;
      if (rdata !== 32'h12345678) begin
         errors++;
         $display("FAIL pre_reset_lw: got %h required 12345678", rdata);
      end
      reset = 1'b1; en = 1'b1; we = 1'b0; size = 2'b10; addr = 6'h08;
      #1;
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_in_reset: got %b required 0", ready);
      end
      @(posedge clk); #1;
      en = 1'b0;
      checks++;
      if (rvalid !== 1'b0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_lw_dropped: got %b/%h required 0/00000000", rvalid, rdata);
      end
      release_and_wait_clear("lw_reset");
      drive(1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL cleared_0x08: got %b/%h required 1/00000000", rvalid, rdata);
      end
   endtask

   initial begin
      test_reset();
      test_read_all_zero("reset");
      test_sign_ext();
      test_lanes();
      test_misalign();
      test_back_to_back();
      test_reset_in_init();
      test_reset_during_lw();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
